// File: rtl/pc_pkg.sv
// Shared encodings for the fetch unit: FSM state values and the default instruction size.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_e;

  localparam int DEFAULT_INSTR_BYTES = 4;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular buffer of the most recent redirect targets; entry 0 is the newest push.
module pc_trace_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic [$clog2(DEPTH)-1:0] sel_i,
  output logic [W-1:0]             data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_idx;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign rd_idx = wr_ptr_q - PW'(1) - sel_i;
  assign data_o = mem_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC with valid/ready request, redirect, stall, halt and misalignment fault.
// Optional redirect trace buffer is built only when PC_TRACE_EN is defined.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int               ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int               INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter int               RC_W         = 16,
  parameter int               TRACE_DEPTH  = 4
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           PCSrc,
  input  logic [ADDR_W-1:0]              Result,
  input  logic                           Stall,
  input  logic                           Halt_Req,
  input  logic                           Resume,
  input  logic                           Fetch_Ready,
  output logic [ADDR_W-1:0]              PC,
  output logic [ADDR_W-1:0]              PC_Plus_4,
  output logic                           Fetch_Valid,
  output logic [1:0]                     State,
  output logic                           Misalign_Fault,
  output logic [ADDR_W-1:0]              Fault_Addr,
  output logic [RC_W-1:0]                Redirect_Count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] Trace_Sel,
  output logic [ADDR_W-1:0]              Trace_Out
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic              misalign_q, misalign_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic              misaligned;
  logic              trace_push;

  assign misaligned = PCSrc && ((Result & ALIGN_MASK) != '0);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    misalign_d   = misalign_q;
    rc_d         = rc_q;
    trace_push   = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (misaligned) begin
          state_d      = ST_FAULT;
          fault_addr_d = Result;
          misalign_d   = 1'b1;
        end else begin
          // A redirect wins over both stall and an unaccepted request.
          if (PCSrc) begin
            pc_d       = Result;
            trace_push = 1'b1;
            if (rc_q != '1) rc_d = rc_q + RC_W'(1);
          end else if (!Stall && Fetch_Ready) begin
            pc_d = pc_q + STEP;
          end
          if (Halt_Req) state_d = ST_HALT;
        end
      end
      ST_HALT: if (Resume) state_d = ST_RUN;
      default: ;
    endcase
    fetch_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      fault_addr_q  <= '0;
      misalign_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      rc_q          <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_addr_q  <= fault_addr_d;
      misalign_q    <= misalign_d;
      fetch_valid_q <= fetch_valid_d;
      rc_q          <= rc_d;
    end
  end

  assign PC             = pc_q;
  assign PC_Plus_4      = pc_q + STEP;
  assign Fetch_Valid    = fetch_valid_q;
  assign State          = state_q;
  assign Misalign_Fault = misalign_q;
  assign Fault_Addr     = fault_addr_q;
  assign Redirect_Count = rc_q;

`ifdef PC_TRACE_EN
  pc_trace_buf #(
    .W     (ADDR_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk    (CLK),
    .rst    (Reset),
    .push_i (trace_push),
    .data_i (Result),
    .sel_i  (Trace_Sel),
    .data_o (Trace_Out)
  );
`else
  logic unused_trace;
  assign unused_trace = &{1'b0, Trace_Sel, trace_push};
  assign Trace_Out    = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit (8-bit addresses): directed vector table, async reset checks,
// trace readback and a randomized run against a behavioural model.
module tb_pc_fetch_unit;

  localparam int AW = 8;
  localparam int IB = 4;
  localparam int RCMAX = 15;
  localparam int TDEPTH = 4;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          PCSrc = 1'b0;
  logic [AW-1:0] Result = '0;
  logic          Stall = 1'b0;
  logic          Halt_Req = 1'b0;
  logic          Resume = 1'b0;
  logic          Fetch_Ready = 1'b0;
  logic [1:0]    Trace_Sel = '0;
  logic [AW-1:0] PC, PC_Plus_4, Fault_Addr, Trace_Out;
  logic          Fetch_Valid, Misalign_Fault;
  logic [1:0]    State;
  logic [3:0]    Redirect_Count;

  pc_fetch_unit #(
    .ADDR_W(AW), .RESET_VECTOR(8'h00), .INSTR_BYTES(IB), .RC_W(4), .TRACE_DEPTH(TDEPTH)
  ) dut (
    .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .Result(Result), .Stall(Stall),
    .Halt_Req(Halt_Req), .Resume(Resume), .Fetch_Ready(Fetch_Ready), .PC(PC),
    .PC_Plus_4(PC_Plus_4), .Fetch_Valid(Fetch_Valid), .State(State),
    .Misalign_Fault(Misalign_Fault), .Fault_Addr(Fault_Addr),
    .Redirect_Count(Redirect_Count), .Trace_Sel(Trace_Sel), .Trace_Out(Trace_Out)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: 0=BOOT 1=RUN 2=HALT 3=FAULT
  int m_state, m_pc, m_fa, m_mf, m_rc;
  int m_tq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_pc = 0; m_fa = 0; m_mf = 0; m_rc = 0;
    m_tq.delete();
  endtask

  task automatic model_step();
    if (Reset) return;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (PCSrc && (int'(Result) % IB) != 0) begin
          m_state = 3; m_fa = int'(Result); m_mf = 1;
        end else begin
          if (PCSrc) begin
            m_pc = int'(Result);
            if (m_rc < RCMAX) m_rc++;
            m_tq.push_front(int'(Result));
            if (m_tq.size() > TDEPTH) m_tq.delete(m_tq.size() - 1);
          end else if (!Stall && Fetch_Ready) begin
            m_pc = (m_pc + IB) % (1 << AW);
          end
          if (Halt_Req) m_state = 2;
        end
      end
      2: if (Resume) m_state = 1;
      default: ;
    endcase
  endtask

  function automatic int exp_trace(input int sel);
`ifdef PC_TRACE_EN
    return (sel < m_tq.size()) ? m_tq[sel] : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".PC"}, 32'(PC), 32'(m_pc));
    chk({tag, ".PC_Plus_4"}, 32'(PC_Plus_4), 32'((m_pc + IB) % (1 << AW)));
    chk({tag, ".Fetch_Valid"}, 32'(Fetch_Valid), 32'(m_state == 1));
    chk({tag, ".State"}, 32'(State), 32'(m_state));
    chk({tag, ".Misalign_Fault"}, 32'(Misalign_Fault), 32'(m_mf));
    chk({tag, ".Fault_Addr"}, 32'(Fault_Addr), 32'(m_fa));
    chk({tag, ".Redirect_Count"}, 32'(Redirect_Count), 32'(m_rc));
    chk({tag, ".Trace_Out"}, 32'(Trace_Out), 32'(exp_trace(int'(Trace_Sel))));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle(input string tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    PCSrc = 0; Result = '0; Stall = 0; Halt_Req = 0; Resume = 0; Fetch_Ready = 0;
  endtask

  task automatic full_reset();
    @(negedge CLK);
    idle_inputs();
    Reset = 1; m_reset();
    @(negedge CLK);
    Reset = 0;
    check_all("reset");
  endtask

  typedef struct packed {
    logic          pcsrc;
    logic [AW-1:0] result;
    logic          stall;
    logic          halt;
    logic          resume;
    logic          ready;
    logic [AW-1:0] exp_pc;
    logic [1:0]    exp_state;
  } vec_t;

  vec_t vecs[15];

  initial begin
    //             pcsrc result stall halt resume ready  exp_pc exp_state
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1};  // BOOT ignores inputs
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 2'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 2'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0C, 2'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C, 2'd1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C, 2'd1};
    vecs[6]  = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 2'd1};  // redirect beats stall
    vecs[7]  = '{1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFC, 2'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1};  // wrap, no fault
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 2'd2};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 2'd2};
    vecs[11] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 2'd2};  // PCSrc ignored in HALT
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 2'd1};
    vecs[13] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 2'd3};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 2'd3};  // Resume cannot leave FAULT
  end

  initial begin
    m_reset();
    full_reset();
    chk("reset.State_const", 32'(State), 32'd0);
    chk("reset.FV_const", 32'(Fetch_Valid), 32'd0);

    // Count up to PC=0x10, then hit Reset between clock edges.
    Fetch_Ready = 1;
    for (int i = 0; i < 5; i++) cycle("count");
    chk("count.PC10", 32'(PC), 32'h10);
    #2;
    Reset = 1; m_reset();
    #1;
    chk("async.PC", 32'(PC), 32'h0);
    chk("async.State", 32'(State), 32'd0);
    chk("async.FV", 32'(Fetch_Valid), 32'd0);
    @(negedge CLK);
    Reset = 0;
    cycle("boot");
    chk("boot.State", 32'(State), 32'd1);
    chk("boot.FV", 32'(Fetch_Valid), 32'd1);
    $display("async reset sequence: PC=%0h State=%0d", PC, State);

    // Directed table from a fresh reset.
    full_reset();
    for (int i = 0; i < 15; i++) begin
      PCSrc = vecs[i].pcsrc; Result = vecs[i].result; Stall = vecs[i].stall;
      Halt_Req = vecs[i].halt; Resume = vecs[i].resume; Fetch_Ready = vecs[i].ready;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.exp_pc", i), 32'(PC), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d.exp_state", i), 32'(State), 32'(vecs[i].exp_state));
      $display("vec %0d: PC=%0h State=%0d RC=%0d MF=%0d FA=%0h",
               i, PC, State, Redirect_Count, Misalign_Fault, Fault_Addr);
    end
    chk("fault.Fault_Addr", 32'(Fault_Addr), 32'h01);
    chk("fault.Misalign", 32'(Misalign_Fault), 32'd1);
    chk("fault.RC", 32'(Redirect_Count), 32'd2);

    // Trace readback after five redirects.
    full_reset();
    cycle("trace.boot");
    for (int i = 1; i <= 5; i++) begin
      PCSrc = 1; Result = AW'(i * 16);
      cycle($sformatf("trace.push%0d", i));
      $display("trace push %0h", Result);
    end
    idle_inputs();
    for (int s = 0; s < 4; s++) begin
      Trace_Sel = 2'(s);
      #1;
`ifdef PC_TRACE_EN
      chk($sformatf("trace.sel%0d", s), 32'(Trace_Out), 32'(8'h50 - 8'(s * 16)));
`else
      chk($sformatf("trace.sel%0d", s), 32'(Trace_Out), 32'd0);
`endif
      $display("trace sel %0d -> %0h", s, Trace_Out);
    end
    @(negedge CLK);

    // Randomized run, occasional resets to escape FAULT.
    full_reset();
    for (int i = 0; i < 1500; i++) begin
      if (Reset) Reset = 0;
      else if ($urandom_range(0, 63) == 0 || (m_state == 3 && $urandom_range(0, 7) == 0)) begin
        Reset = 1; m_reset();
      end
      PCSrc = ($urandom_range(0, 5) == 0);
      Result = AW'($urandom);
      if ($urandom_range(0, 11) != 0) Result[1:0] = 2'b00;
      Stall = ($urandom_range(0, 3) == 0);
      Fetch_Ready = ($urandom_range(0, 9) < 7);
      Halt_Req = ($urandom_range(0, 15) == 0);
      Resume = ($urandom_range(0, 3) == 0);
      Trace_Sel = 2'($urandom);
      cycle($sformatf("rand%0d", i));
      $display("rand %0d: rst=%0d src=%0d res=%0h PC=%0h St=%0d RC=%0d TO=%0h",
               i, Reset, PCSrc, Result, PC, State, Redirect_Count, Trace_Out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
